// File: rtl/pc_reg_if.sv
// Program-counter bus between next-PC mux and pc_reg.
// PC_ALIGN_CHECK_EN adds the misaligned flag.
interface pc_reg_if #(
    parameter int WIDTH = 16
);
    logic             stall;
    logic [WIDTH-1:0] nextInst;
    logic [WIDTH-1:0] currentInst;
    logic [WIDTH-1:0] pcPlusInc;
    logic             updated;
`ifdef PC_ALIGN_CHECK_EN
    logic             misaligned;
`endif

    modport master (
        output stall,
        output nextInst,
        input  currentInst,
        input  pcPlusInc,
`ifdef PC_ALIGN_CHECK_EN
        input  misaligned,
`endif
        input  updated
    );

    modport slave (
        input  stall,
        input  nextInst,
        output currentInst,
        output pcPlusInc,
`ifdef PC_ALIGN_CHECK_EN
        output misaligned,
`endif
        output updated
    );
endinterface

// File: rtl/pc_reg.sv
// Program-counter register with stall hold and sequential-address output.
// Optional PC_ALIGN_CHECK_EN: clears bit 0 on load and flags it in misaligned.
module pc_reg #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               INC       = 2
) (
    input logic     clk,
    input logic     rst_n,
    pc_reg_if.slave bus
);
    logic [WIDTH-1:0] r_pc;
    logic             r_updated;
    logic [WIDTH-1:0] w_next;
    logic             w_load;

    assign w_load = ~bus.stall;

`ifdef PC_ALIGN_CHECK_EN
    logic r_misaligned;

    assign w_next = {bus.nextInst[WIDTH-1:1], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else if (w_load) begin
            r_misaligned <= bus.nextInst[0];
        end
    end

    assign bus.misaligned = r_misaligned;
`else
    assign w_next = bus.nextInst;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_VAL;
            r_updated <= 1'b0;
        end else if (w_load) begin
            r_pc      <= w_next;
            r_updated <= 1'b1;
        end else begin
            r_updated <= 1'b0;
        end
    end

    // Wraps modulo 2^WIDTH; carry is intentionally dropped.
    assign bus.pcPlusInc   = r_pc + WIDTH'(INC);
    assign bus.currentInst = r_pc;
    assign bus.updated     = r_updated;
endmodule

// File: tb/tb_pc_reg.sv
// Directed self-checking bench for pc_reg.
// Define PC_ALIGN_CHECK_EN to also exercise the alignment flag.
`timescale 1ns/1ps
module tb_pc_reg;
    logic clk;
    logic rst_n;
    logic run;
    int   n_chk;
    int   n_err;

    pc_reg_if #(.WIDTH(16)) u_if ();

    pc_reg #(
        .WIDTH    (16),
        .RESET_VAL(16'h0000),
        .INC      (2)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if.slave)
    );

    // Clock held idle until run is set; period 200 ns.
    always #100 if (run) clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        clk   = 1'b0;
        run   = 1'b0;
        rst_n = 1'b0;
        u_if.stall    = 1'b0;
        u_if.nextInst = 16'h1234;
        #10;
        chk("rst_cur", 32'(u_if.currentInst), 32'h0000);
        chk("rst_upd", 32'(u_if.updated), 32'h0);
        chk("rst_plus", 32'(u_if.pcPlusInc), 32'h0002);
`ifdef PC_ALIGN_CHECK_EN
        chk("rst_mis", 32'(u_if.misaligned), 32'h0);
`endif
        rst_n = 1'b1;
        #10;
        chk("rel_noedge", 32'(u_if.currentInst), 32'h0000);
        run = 1'b1;
        tick();
        chk("rel_cur", 32'(u_if.currentInst), 32'h1234);
        chk("rel_upd", 32'(u_if.updated), 32'h1);

        // Sequential fetch: nextInst steps by 2 every half period,
        // changing 50 ns away from each rising edge.
        #149;
        u_if.nextInst = 16'h0000;
        tick();
        chk("seq_cur0", 32'(u_if.currentInst), 32'h0000);
        chk("seq_plus0", 32'(u_if.pcPlusInc), 32'h0002);
        for (int k = 1; k <= 5; k++) begin
            #49;
            u_if.nextInst = 16'(4 * k - 2);
            #1;
            chk("seq_stable", 32'(u_if.currentInst), 32'(4 * (k - 1)));
            #99;
            u_if.nextInst = 16'(4 * k);
            tick();
            chk("seq_cur", 32'(u_if.currentInst), 32'(4 * k));
            chk("seq_plus", 32'(u_if.pcPlusInc), 32'(4 * k + 2));
            chk("seq_upd", 32'(u_if.updated), 32'h1);
        end

        // Stall hold.
        u_if.nextInst = 16'h0010;
        tick();
        chk("stl_pre", 32'(u_if.currentInst), 32'h0010);
        u_if.stall    = 1'b1;
        u_if.nextInst = 16'h0020;
        tick();
        chk("stl_cur1", 32'(u_if.currentInst), 32'h0010);
        chk("stl_upd1", 32'(u_if.updated), 32'h0);
        tick();
        chk("stl_cur2", 32'(u_if.currentInst), 32'h0010);
        chk("stl_upd2", 32'(u_if.updated), 32'h0);
        u_if.stall = 1'b0;
        tick();
        chk("stl_rel", 32'(u_if.currentInst), 32'h0020);
        chk("stl_relupd", 32'(u_if.updated), 32'h1);

        // Wrap-around of the increment output.
        u_if.nextInst = 16'hFFFE;
        tick();
        chk("wrp_cur", 32'(u_if.currentInst), 32'hFFFE);
        chk("wrp_plus", 32'(u_if.pcPlusInc), 32'h0000);
        u_if.nextInst = 16'hFFFF;
        tick();
`ifdef PC_ALIGN_CHECK_EN
        chk("odd_cur", 32'(u_if.currentInst), 32'hFFFE);
        chk("odd_plus", 32'(u_if.pcPlusInc), 32'h0000);
        chk("odd_mis", 32'(u_if.misaligned), 32'h1);
        u_if.nextInst = 16'h0033;
        tick();
        chk("al_cur", 32'(u_if.currentInst), 32'h0032);
        chk("al_mis1", 32'(u_if.misaligned), 32'h1);
        u_if.stall    = 1'b1;
        u_if.nextInst = 16'h0040;
        tick();
        chk("al_hold", 32'(u_if.misaligned), 32'h1);
        u_if.stall = 1'b0;
        tick();
        chk("al_cur2", 32'(u_if.currentInst), 32'h0040);
        chk("al_mis0", 32'(u_if.misaligned), 32'h0);
`else
        chk("odd_cur", 32'(u_if.currentInst), 32'hFFFF);
        chk("odd_plus", 32'(u_if.pcPlusInc), 32'h0001);
        u_if.nextInst = 16'h0033;
        tick();
        chk("odd_cur2", 32'(u_if.currentInst), 32'h0033);
        chk("odd_plus2", 32'(u_if.pcPlusInc), 32'h0035);
`endif

        // Asynchronous reset between edges.
        u_if.nextInst = 16'h0100;
        tick();
        chk("ar_pre", 32'(u_if.currentInst), 32'h0100);
        #50;
        rst_n = 1'b0;
        #1;
        chk("ar_cur", 32'(u_if.currentInst), 32'h0000);
        chk("ar_upd", 32'(u_if.updated), 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        chk("ar_mis", 32'(u_if.misaligned), 32'h0);
`endif
        tick();
        chk("ar_held", 32'(u_if.currentInst), 32'h0000);
        rst_n = 1'b1;
        tick();
        chk("ar_rel", 32'(u_if.currentInst), 32'h0100);
        chk("ar_relupd", 32'(u_if.updated), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
